fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage feeding the control FSM and decode.
- Reads one or two 16-bit instruction words from instruction memory at the PC, holds them stable for decode, and raises fetch_complete.
- Advances or loads the PC when control issues a fetch_operation_t command in its EXECUTE state.

Parameters:
ADDR_WIDTH, 13, word-address width of the PC and instruction memory
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst_async  input  1  reset
fetch_operation  input  fetch_operation_t  command from control: FETCH_NOP, FETCH_INC_PC, FETCH_LOAD_PC (cpu_common)
jump_addr  input  ADDR_WIDTH  target PC, used only with FETCH_LOAD_PC
fetch_complete  output  1  instruction words valid and stable
inst_word0  output  16  first instruction word
inst_word1  output  16  second word; valid only when inst_len=1
inst_len  output  1  0 = one word, 1 = two words (equals inst_word0[15])
pc  output  ADDR_WIDTH  address of the held instruction
pc_next  output  ADDR_WIDTH  pc + 1 + inst_len, modulo 2^ADDR_WIDTH (return address)
mem_rd_en  output  1  instruction memory read strobe
mem_addr  output  ADDR_WIDTH  instruction memory read address
mem_rdata  input  16  read data, valid exactly 1 cycle after mem_rd_en

Behaviour:
- Reset: clk; rst_async, asynchronous, active-high.
- Values held while reset is asserted:
  - state = ISSUE0, pc = RESET_PC.
  - inst_word0 = 0, inst_word1 = 0, inst_len = 0, fetch_complete = 0.
  - mem_rd_en = 1, mem_addr = RESET_PC. Memory outputs decode from the state, so a read is presented during reset; this is harmless.
- Fetching begins automatically on the first clk edge after reset deasserts.
- States:
  - ISSUE0: mem_rd_en = 1, mem_addr = pc. Next state is CAPTURE0.
  - CAPTURE0: latch inst_word0 <= mem_rdata and inst_len <= mem_rdata[15]. If mem_rdata[15] = 1, go to ISSUE1; otherwise go to DONE.
  - ISSUE1: mem_rd_en = 1, mem_addr = pc + 1 (wraps). Next state is CAPTURE1.
  - CAPTURE1: latch inst_word1 <= mem_rdata. Next state is DONE.
  - DONE: fetch_complete = 1. Stay in DONE while fetch_operation = FETCH_NOP.
    - FETCH_INC_PC: pc <= pc + 1 + inst_len (wraps), next state is ISSUE0.
    - FETCH_LOAD_PC: pc <= jump_addr, next state is ISSUE0.
- mem_rd_en = 0 in CAPTURE0, CAPTURE1 and DONE.
- Latency, counted from entry to ISSUE0:
  - One-word instruction: fetch_complete rises 2 cycles later.
  - Two-word instruction: fetch_complete rises 4 cycles later.
- fetch_complete is a level decoded from the state register, with no combinational path from inputs.
  - It deasserts the cycle after DONE samples FETCH_INC_PC or FETCH_LOAD_PC.
  - Control therefore never sees a stale complete on return to its FETCH state.
- In DONE, inst_word0, inst_word1, inst_len, pc and pc_next hold constant. In other states their values are don't-care for consumers.
- inst_word1 is not cleared on a one-word fetch; it retains its old value.
- fetch_operation other than FETCH_NOP outside DONE is ignored, and the bench flags it as a protocol error. An in-flight fetch is never aborted.
- FETCH_LOAD_PC with jump_addr equal to pc refetches the same address; it is legal.
- Wrap: pc = 2^ADDR_WIDTH-1 with a two-word instruction reads word1 from address 0. FETCH_INC_PC then gives pc = 1.
- Reset mid-fetch: state, pc and outputs return immediately (asynchronously) to reset values, and the captured partial instruction is discarded.
- An unreachable state encoding recovers to ISSUE0 on the next edge.

Test Plan:
- Reset release, mem[0]=0x1234 -> mem_rd_en=1 and mem_addr=0 in cycle 0; fetch_complete=1 in cycle 2; inst_word0=0x1234, inst_len=0, pc=0, pc_next=1.
- mem[0]=0x8001, mem[1]=0xBEEF -> mem_addr sequence 0 then 1; fetch_complete at cycle 4; inst_word0=0x8001, inst_word1=0xBEEF, inst_len=1, pc_next=2.
- In DONE: hold FETCH_NOP 5 cycles -> outputs stable, no reads. Then pulse FETCH_INC_PC one cycle -> fetch_complete=0 next cycle, mem_addr=2 in ISSUE0.
- FETCH_LOAD_PC with jump_addr=0x0ABC -> next read at 0x0ABC; pc=0x0ABC when fetch_complete rises.
- pc=0x1FFF with mem[0x1FFF]=0x8000 and mem[0]=0x0042 -> ISSUE1 reads address 0, inst_word1=0x0042, pc_next=1; after FETCH_INC_PC, pc=1.
- Assert rst_async during CAPTURE1 -> fetch_complete=0 and pc=RESET_PC immediately; after release, the fetch restarts from address 0 with 2- or 4-cycle latency.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_common / fetch_unit_if                                                  |
// | Fetch command type and the fetch stage's control, decode and imem bus.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

package cpu_common;
  typedef enum logic [1:0] {
    FETCH_NOP     = 2'd0,
    FETCH_INC_PC  = 2'd1,
    FETCH_LOAD_PC = 2'd2
  } fetch_operation_t;
endpackage

interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 13
);
  import cpu_common::*;

  fetch_operation_t        fetch_operation;
  logic [ADDR_WIDTH-1:0]   jump_addr;
  logic                    fetch_complete;
  logic [15:0]             inst_word0;
  logic [15:0]             inst_word1;
  logic                    inst_len;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [15:0]             mem_rdata;

  // The fetch unit itself.
  modport master (
    input  fetch_operation, jump_addr, mem_rdata,
    output fetch_complete, inst_word0, inst_word1, inst_len,
           pc, pc_next, mem_rd_en, mem_addr
  );

  // Control, decode and instruction memory.
  modport slave (
    output fetch_operation, jump_addr, mem_rdata,
    input  fetch_complete, inst_word0, inst_word1, inst_len,
           pc, pc_next, mem_rd_en, mem_addr
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                  |
// | Fetches 1- or 2-word instructions at the PC and holds them for decode.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

module fetch_unit #(
  parameter int          ADDR_WIDTH = 13,
  parameter int unsigned RESET_PC   = 0
) (
  input  wire logic    clk,
  input  wire logic    rst_async,
  fetch_unit_if.master bus
);
  import cpu_common::*;

  typedef enum logic [2:0] {
    ISSUE0   = 3'd0,
    CAPTURE0 = 3'd1,
    ISSUE1   = 3'd2,
    CAPTURE1 = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_RESET_PC = ADDR_WIDTH'(RESET_PC);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_word0;
  logic [15:0]           r_word1;
  logic                  r_len;
  logic [ADDR_WIDTH-1:0] w_pc_plus1;
  logic [ADDR_WIDTH-1:0] w_pc_next;

  assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);
  assign w_pc_next  = w_pc_plus1 + ADDR_WIDTH'(r_len);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= ISSUE0;
      r_pc    <= C_RESET_PC;
      r_word0 <= 16'h0000;
      r_word1 <= 16'h0000;
      r_len   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        CAPTURE0: begin
          r_word0 <= bus.mem_rdata;
          r_len   <= bus.mem_rdata[15];
        end
        CAPTURE1: r_word1 <= bus.mem_rdata;
        DONE: begin
          if (bus.fetch_operation == FETCH_INC_PC) begin
            r_pc <= w_pc_next;
          end else if (bus.fetch_operation == FETCH_LOAD_PC) begin
            r_pc <= bus.jump_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and fetch_complete decode purely from state, so the
  // read at RESET_PC is already presented while reset is held.
  always_comb begin
    w_next_state       = ISSUE0;
    bus.mem_rd_en      = 1'b0;
    bus.mem_addr       = r_pc;
    bus.fetch_complete = 1'b0;
    case (r_state)
      ISSUE0: begin
        bus.mem_rd_en = 1'b1;
        w_next_state  = CAPTURE0;
      end
      CAPTURE0: w_next_state = bus.mem_rdata[15] ? ISSUE1 : DONE;
      ISSUE1: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = w_pc_plus1;
        w_next_state  = CAPTURE1;
      end
      CAPTURE1: w_next_state = DONE;
      DONE: begin
        bus.fetch_complete = 1'b1;
        w_next_state = (bus.fetch_operation == FETCH_INC_PC ||
                        bus.fetch_operation == FETCH_LOAD_PC) ? ISSUE0 : DONE;
      end
      default: w_next_state = ISSUE0;
    endcase
  end

  assign bus.inst_word0 = r_word0;
  assign bus.inst_word1 = r_word1;
  assign bus.inst_len   = r_len;
  assign bus.pc         = r_pc;
  assign bus.pc_next    = w_pc_next;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                               |
// | Directed self-checking bench for fetch_unit with a 1-cycle-latency imem.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

module tb_fetch_unit;
  import cpu_common::*;

  localparam int AW = 13;

  logic clk;
  logic rst_async;
  int   checks;
  int   errors;

  logic [15:0] mem [0:(1<<AW)-1];

  fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Counts negedges from the ISSUE0 cycle until fetch_complete; -1 on timeout.
  task automatic wait_complete(input int max_cycles, output int n);
    n = 0;
    while (!bus.fetch_complete && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!bus.fetch_complete) n = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.fetch_complete !== 1'b0) begin errors++; $display("FAIL rst_complete got %h exp 0", bus.fetch_complete); end
    checks++; if (bus.mem_rd_en !== 1'b1) begin errors++; $display("FAIL rst_rd_en got %h exp 1", bus.mem_rd_en); end
    checks++; if (bus.mem_addr !== 13'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.mem_addr); end
    checks++; if (bus.pc !== 13'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.pc); end
    checks++; if ({bus.inst_word0, bus.inst_word1, bus.inst_len} !== 33'h0) begin errors++;
      $display("FAIL rst_words got %h %h %h exp 0 0 0", bus.inst_word0, bus.inst_word1, bus.inst_len); end
  endtask

  task automatic test_one_word();
    mem[0] = 16'h1234;
    rst_async = 1'b0;
    #1;
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h0) begin errors++;
      $display("FAIL one_c0 got rd=%h addr=%h exp rd=1 addr=0", bus.mem_rd_en, bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.fetch_complete !== 1'b0 || bus.mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL one_c1 got fc=%h rd=%h exp fc=0 rd=0", bus.fetch_complete, bus.mem_rd_en); end
    @(negedge clk);
    checks++; if (bus.fetch_complete !== 1'b1) begin errors++; $display("FAIL one_c2_fc got %h exp 1", bus.fetch_complete); end
    checks++; if (bus.inst_word0 !== 16'h1234 || bus.inst_len !== 1'b0) begin errors++;
      $display("FAIL one_word got w0=%h len=%h exp w0=1234 len=0", bus.inst_word0, bus.inst_len); end
    checks++; if (bus.pc !== 13'h0 || bus.pc_next !== 13'h1) begin errors++;
      $display("FAIL one_pc got pc=%h pcn=%h exp pc=0 pcn=1", bus.pc, bus.pc_next); end
  endtask

  task automatic test_two_word();
    rst_async = 1'b1;
    mem[0] = 16'h8001;
    mem[1] = 16'hBEEF;
    mem[2] = 16'h0007;
    @(negedge clk);
    rst_async = 1'b0;
    #1;
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h0) begin errors++;
      $display("FAIL two_c0 got rd=%h addr=%h exp rd=1 addr=0", bus.mem_rd_en, bus.mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h1) begin errors++;
      $display("FAIL two_c2 got rd=%h addr=%h exp rd=1 addr=1", bus.mem_rd_en, bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.fetch_complete !== 1'b0) begin errors++; $display("FAIL two_c3_fc got %h exp 0", bus.fetch_complete); end
    @(negedge clk);
    checks++; if (bus.fetch_complete !== 1'b1) begin errors++; $display("FAIL two_c4_fc got %h exp 1", bus.fetch_complete); end
    checks++; if (bus.inst_word0 !== 16'h8001 || bus.inst_word1 !== 16'hBEEF || bus.inst_len !== 1'b1) begin errors++;
      $display("FAIL two_words got %h %h %h exp 8001 beef 1", bus.inst_word0, bus.inst_word1, bus.inst_len); end
    checks++; if (bus.pc_next !== 13'h2) begin errors++; $display("FAIL two_pcn got %h exp 2", bus.pc_next); end
  endtask

  task automatic test_hold_and_inc();
    int n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.fetch_complete !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.inst_word0 !== 16'h8001 ||
                    bus.inst_word1 !== 16'hBEEF || bus.pc !== 13'h0) begin errors++;
        $display("FAIL hold_%0d got fc=%h rd=%h w0=%h w1=%h pc=%h exp 1 0 8001 beef 0", i,
                 bus.fetch_complete, bus.mem_rd_en, bus.inst_word0, bus.inst_word1, bus.pc); end
    end
    bus.fetch_operation = FETCH_INC_PC;
    @(negedge clk);
    bus.fetch_operation = FETCH_NOP;
    checks++; if (bus.fetch_complete !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h2) begin errors++;
      $display("FAIL inc_issue got fc=%h rd=%h addr=%h exp 0 1 2", bus.fetch_complete, bus.mem_rd_en, bus.mem_addr); end
    wait_complete(8, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL inc_latency got %0d exp 2", n); end
    checks++; if (bus.pc !== 13'h2 || bus.inst_word0 !== 16'h0007 || bus.pc_next !== 13'h3) begin errors++;
      $display("FAIL inc_result got pc=%h w0=%h pcn=%h exp 2 0007 3", bus.pc, bus.inst_word0, bus.pc_next); end
  endtask

  task automatic test_load_pc();
    int n;
    mem[13'h0ABC] = 16'h1111;
    for (int k = 0; k < 2; k++) begin
      bus.fetch_operation = FETCH_LOAD_PC;
      bus.jump_addr = 13'h0ABC;
      @(negedge clk);
      bus.fetch_operation = FETCH_NOP;
      bus.jump_addr = 13'h0;
      checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h0ABC) begin errors++;
        $display("FAIL load%0d_issue got rd=%h addr=%h exp 1 0abc", k, bus.mem_rd_en, bus.mem_addr); end
      wait_complete(8, n);
      checks++; if (n !== 2 || bus.pc !== 13'h0ABC || bus.pc_next !== 13'h0ABD || bus.inst_word0 !== 16'h1111) begin errors++;
        $display("FAIL load%0d_done got n=%0d pc=%h pcn=%h w0=%h exp 2 0abc 0abd 1111", k, n, bus.pc, bus.pc_next, bus.inst_word0); end
    end
  endtask

  task automatic test_wrap();
    int n;
    mem[13'h1FFF] = 16'h8000;
    mem[0] = 16'h0042;
    bus.fetch_operation = FETCH_LOAD_PC;
    bus.jump_addr = 13'h1FFF;
    @(negedge clk);
    bus.fetch_operation = FETCH_NOP;
    checks++; if (bus.mem_addr !== 13'h1FFF) begin errors++; $display("FAIL wrap_a0 got %h exp 1fff", bus.mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 13'h0) begin errors++;
      $display("FAIL wrap_a1 got rd=%h addr=%h exp 1 0", bus.mem_rd_en, bus.mem_addr); end
    wait_complete(8, n);
    checks++; if (n !== 2 || bus.inst_word0 !== 16'h8000 || bus.inst_word1 !== 16'h0042 || bus.pc_next !== 13'h1) begin errors++;
      $display("FAIL wrap_done got n=%0d w0=%h w1=%h pcn=%h exp 2 8000 0042 1", n, bus.inst_word0, bus.inst_word1, bus.pc_next); end
    bus.fetch_operation = FETCH_INC_PC;
    @(negedge clk);
    bus.fetch_operation = FETCH_NOP;
    checks++; if (bus.mem_addr !== 13'h1) begin errors++; $display("FAIL wrap_inc_addr got %h exp 1", bus.mem_addr); end
    wait_complete(8, n);
    checks++; if (n !== 4 || bus.pc !== 13'h1 || bus.inst_word0 !== 16'hBEEF || bus.inst_word1 !== 16'h0007) begin errors++;
      $display("FAIL wrap_inc got n=%0d pc=%h w0=%h w1=%h exp 4 1 beef 0007", n, bus.pc, bus.inst_word0, bus.inst_word1); end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    mem[13'h0010] = 16'h8123;
    mem[13'h0011] = 16'h4444;
    bus.fetch_operation = FETCH_LOAD_PC;
    bus.jump_addr = 13'h0010;
    @(negedge clk);
    bus.fetch_operation = FETCH_NOP;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_async = 1'b1;
    #1;
    checks++; if (bus.fetch_complete !== 1'b0 || bus.pc !== 13'h0 || bus.mem_addr !== 13'h0 || bus.mem_rd_en !== 1'b1) begin errors++;
      $display("FAIL midrst_async got fc=%h pc=%h addr=%h rd=%h exp 0 0 0 1", bus.fetch_complete, bus.pc, bus.mem_addr, bus.mem_rd_en); end
    checks++; if (bus.inst_word0 !== 16'h0 || bus.inst_word1 !== 16'h0 || bus.inst_len !== 1'b0) begin errors++;
      $display("FAIL midrst_words got %h %h %h exp 0 0 0", bus.inst_word0, bus.inst_word1, bus.inst_len); end
    @(negedge clk);
    rst_async = 1'b0;
    wait_complete(8, n);
    checks++; if (n !== 2 || bus.pc !== 13'h0 || bus.inst_word0 !== 16'h0042 || bus.inst_len !== 1'b0 || bus.inst_word1 !== 16'h0) begin errors++;
      $display("FAIL midrst_refetch got n=%0d pc=%h w0=%h len=%h w1=%h exp 2 0 0042 0 0", n, bus.pc, bus.inst_word0, bus.inst_len, bus.inst_word1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_async = 1'b1;
    bus.fetch_operation = FETCH_NOP;
    bus.jump_addr = '0;
    for (int a = 0; a < (1<<AW); a++) mem[a] = 16'h0000;
    test_reset();
    test_one_word();
    test_two_word();
    test_hold_and_inc();
    test_load_pc();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
